// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_pkg
// Purpose  : Shared widths, latency limit and channel state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

   localparam int C_ADDR_W  = 32;
   localparam int C_DATA_W  = 32;
   localparam int C_MAX_LAT = 15;
   localparam int C_CNT_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } chan_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_chan_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_chan_timer
// Purpose  : Per-channel IDLE/WAIT/ACK sequencer with programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module mem_chan_timer
   import mem_responder_pkg::*;
#(
   parameter int LAT = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   output logic o_accept,
   output logic o_ack,
   output logic o_commit
);

   localparam int C_LAT_CLAMP = (LAT > C_MAX_LAT) ? C_MAX_LAT : ((LAT < 1) ? 1 : LAT);
   localparam logic [C_CNT_W-1:0] C_LOAD = C_CNT_W'(C_LAT_CLAMP - 1);

   chan_state_t        r_state;
   chan_state_t        w_state_nxt;
   logic [C_CNT_W-1:0] r_cnt;
   logic [C_CNT_W-1:0] w_cnt_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // o_commit marks the edge that enters ACK; data movement happens on that edge
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_accept    = 1'b0;
      o_ack       = 1'b0;
      o_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_req) begin
               o_accept  = 1'b1;
               w_cnt_nxt = C_LOAD;
               if (C_LOAD == '0) begin
                  w_state_nxt = ST_ACK;
                  o_commit    = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == C_CNT_W'(1)) begin
               w_state_nxt = ST_ACK;
               o_commit    = 1'b1;
            end
         end
         ST_ACK: begin
            o_ack       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : On-chip word memory answering independent read/write channels.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W     = C_ADDR_W,
   parameter int DATA_W     = C_DATA_W,
   parameter int DEPTH_LOG2 = 12,
   parameter int RD_LAT     = 2,
   parameter int WR_LAT     = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              c_re,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [DATA_W-1:0] m_rdata,
   output logic              m_rack,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] m_wdata,
   output logic              m_wack
);

   localparam int C_DEPTH = 1 << DEPTH_LOG2;

   logic                  w_rd_accept;
   logic                  w_rd_commit;
   logic                  w_wr_accept;
   logic                  w_wr_commit;
   logic [DEPTH_LOG2-1:0] r_rd_idx;
   logic [DEPTH_LOG2-1:0] r_wr_idx;
   logic [DEPTH_LOG2-1:0] w_rd_idx;
   logic [DEPTH_LOG2-1:0] w_wr_idx;
   logic [DATA_W-1:0]     r_wr_data;
   logic [DATA_W-1:0]     w_wr_data;
   logic [DATA_W-1:0]     r_rdata;
   logic [DATA_W-1:0]     r_mem [C_DEPTH];
   logic                  w_unused_addr;

   mem_chan_timer #(.LAT(RD_LAT)) u_rd_timer (
      .clk      (clk),
      .rst      (rst),
      .i_req    (c_re),
      .o_accept (w_rd_accept),
      .o_ack    (m_rack),
      .o_commit (w_rd_commit)
   );

   mem_chan_timer #(.LAT(WR_LAT)) u_wr_timer (
      .clk      (clk),
      .rst      (rst),
      .i_req    (c_we),
      .o_accept (w_wr_accept),
      .o_ack    (m_wack),
      .o_commit (w_wr_commit)
   );

   // With a latency of 1 the commit edge is the accept edge, so use the live bus
   assign w_rd_idx  = w_rd_accept ? read_addr[DEPTH_LOG2+1:2]  : r_rd_idx;
   assign w_wr_idx  = w_wr_accept ? write_addr[DEPTH_LOG2+1:2] : r_wr_idx;
   assign w_wr_data = w_wr_accept ? m_wdata                    : r_wr_data;

   assign w_unused_addr = ^{read_addr[ADDR_W-1:DEPTH_LOG2+2], read_addr[1:0],
                            write_addr[ADDR_W-1:DEPTH_LOG2+2], write_addr[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_idx  <= '0;
         r_wr_idx  <= '0;
         r_wr_data <= '0;
      end else begin
         if (w_rd_accept) begin
            r_rd_idx <= read_addr[DEPTH_LOG2+1:2];
         end
         if (w_wr_accept) begin
            r_wr_idx  <= write_addr[DEPTH_LOG2+1:2];
            r_wr_data <= m_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_commit) begin
         r_mem[w_wr_idx] <= w_wr_data;
      end
   end

   // Same-edge read and write of one word returns the pre-write contents
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
      end else if (w_rd_commit) begin
         r_rdata <= r_mem[w_rd_idx];
      end
   end

   assign m_rdata = r_rdata;

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU external memory interface; the other end of the read/write request protocol issued by the CPU top.
- Serves independent read and write channels from an on-chip word array with programmable per-channel latency.
- Answers each request with a one-cycle acknowledge.
- Serves as the synthesizable on-chip memory and as the simulation memory model for the CPU top.

Parameters:
- ADDR_W, 32, byte address width; matches the CPU address bus.
- DATA_W, 32, data word width; matches the CPU data bus.
- DEPTH_LOG2, 12, log2 of the number of words in the array.
- RD_LAT, 2, cycles from read accept to m_rack pulse; legal range 1..15.
- WR_LAT, 1, cycles from write accept to m_wack pulse; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- c_re  input  1  read request; held by the requester until m_rack.
- read_addr  input  ADDR_W  read byte address; stable while c_re is high.
- m_rdata  output  DATA_W  read data; connects to the CPU data_in.
- m_rack  output  1  read acknowledge; one-cycle pulse.
- c_we  input  1  write request; held by the requester until m_wack.
- write_addr  input  ADDR_W  write byte address; stable while c_we is high.
- m_wdata  input  DATA_W  write data; connects to the CPU data_out; stable while c_we is high.
- m_wack  output  1  write acknowledge; one-cycle pulse.

Behaviour:
- Reset (rst low, asynchronous):
  - m_rdata=0, m_rack=0, m_wack=0.
  - Both channel FSMs go to IDLE; both counters clear to 0.
  - Array contents are not reset.
- Word index = addr[DEPTH_LOG2+1:2]. Low two bits are ignored. Address bits above the index are ignored, so out-of-range addresses wrap.
- Each channel runs its own FSM: IDLE, WAIT, ACK.
  - IDLE: if the request is high at the clock edge, latch the address (and m_wdata for write) and load the counter with LAT-1.
    - If LAT-1 is 0, go directly to ACK; otherwise go to WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0, go to ACK.
  - ACK: the ack output is high for exactly this one cycle, then the FSM returns to IDLE.
- Net latency: ack rises LAT cycles after the accept edge.
  - With RD_LAT=1, a request first high at edge N gets m_rack high during cycle N+1.
  - Back-to-back requests: one accepted request per LAT+1 cycles.
- Requester rule: deassert the request in the cycle after ack, or keep it high to present the next request. A request still high in the cycle after ACK is treated as a new request.
- Read data:
  - m_rdata is registered from the array on the edge that enters ACK and is valid while m_rack=1.
  - m_rdata holds its value after ack until the next read completes.
- Write commit:
  - The array is written with the latched data on the edge that enters ACK.
  - Aborting via reset before that edge commits nothing.
- Same-edge read-complete and write-commit to the same word: read-before-write. m_rdata gets the old value.
- A read accepted after m_wack was seen gets the new value.
- Request inputs are ignored in WAIT and ACK. Address or data changes during WAIT have no effect because they were latched at accept.
- Read and write channels are fully concurrent, and both may ack in the same cycle.
- Reset mid-operation: no ack is emitted for the aborted request, and the FSM restarts in IDLE.

Decomposition:
- Shared definitions header:
  - Bus width constants (address and data widths).
  - Channel state encodings (IDLE=2'd0, WAIT=2'd1, ACK=2'd2).
  - Maximum latency constant (15).
- One sub-module, mem_chan_timer:
  - Holds the IDLE/WAIT/ACK FSM and the 4-bit counter.
  - Parameterised by LAT.
  - Outputs accept, ack and commit strobes.
  - Instantiated once per channel.
- The top level holds the array, the address/data latches and the read register.

Test Plan:
1. Reset: hold rst low 3 cycles with c_re=1 and c_we=1 -> m_rack=0, m_wack=0, m_rdata=0 throughout. After release, both requests are accepted on the first edge.
2. Write then read, RD_LAT=2, WR_LAT=1:
   - Write 0xDEADBEEF to address 0x10 -> m_wack pulses exactly 1 cycle after accept.
   - Then read 0x10 -> m_rack exactly 2 cycles after accept with m_rdata=0xDEADBEEF.
3. Back-to-back reads, RD_LAT=1: c_re held high over addresses 0x0, 0x4, 0x8 preloaded with 1, 2, 3 -> m_rack every 2nd cycle with data 1, 2, 3.
4. Same-word collision: pre-write 0xAAAA at 0x20. Align a read and a write of 0x5555 to 0x20 so both ack in the same cycle -> m_rdata=0xAAAA. A following read returns 0x5555.
5. Aliasing, DEPTH_LOG2=12: write 0x1234 to 0x4000 -> a read of 0x0 returns 0x1234. A read of 0x3 also returns 0x1234 (low bits ignored).
6. Reset abort, WR_LAT=4: accept a write of 0x77 to 0x40, then assert rst 2 cycles later -> no m_wack, and word 0x40 keeps its old value.
